// File: rtl/vga_flash_pkg.sv
// Shared widths, defaults and the fetch-state encoding for the flash-to-VGA pixel path.
package vga_flash_pkg;
    localparam int FL_ADDR_W       = 22;
    localparam int PIX_W           = 8;
    localparam int DEF_ACC_CYCLES  = 5;
    localparam int DEF_FRAME_BYTES = 76800;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DONE
    } fetchState_t;
endpackage

// File: rtl/pix_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever the FIFO is non-empty.
module pix_sync_fifo
    import vga_flash_pkg::*;
#(
    parameter int WIDTH = PIX_W,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // Flush wins over everything; pops of an empty FIFO and pushes into a full one are dropped.
    assign w_doPush = push & ~full & ~flush;
    assign w_doPop  = pop & ~empty & ~flush;

    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
        end
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rdPtr];
endmodule

// File: rtl/flash_pixel_fetcher.sv
// Streams one frame of RGB332 bytes from parallel NOR flash, one read in flight, into a show-ahead FIFO.
module flash_pixel_fetcher
    import vga_flash_pkg::*;
#(
    parameter int          ADDR_W      = FL_ADDR_W,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int          ACC_CYCLES  = DEF_ACC_CYCLES,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic              busy,
    output logic [ADDR_W-1:0] FL_ADDR,
    input  logic [PIX_W-1:0]  FL_DQ,
    output logic              FL_OE_N,
    output logic              FL_CE_N,
    output logic              FL_WE_N,
    output logic              FL_RST_N
);
    localparam int CNT_W  = $clog2(FRAME_BYTES + 1);
    localparam int WCNT_W = $clog2(ACC_CYCLES + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    fetchState_t       r_state;
    fetchState_t       w_nextState;
    logic [CNT_W-1:0]  r_addrCnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_flAddr;
    logic              r_oeN;
    logic              r_underflow;
    logic              w_frameDone;
    logic              w_fifoRoom;
    logic              w_issue;
    logic              w_push;
    logic              w_oeNNext;
    logic              w_empty;
    logic              w_full;
    logic [FCNT_W-1:0] w_fifoCount;
    logic [ADDR_W-1:0] w_addrSum;

    assign w_frameDone = (r_addrCnt == CNT_W'(FRAME_BYTES));
    assign w_fifoRoom  = (w_fifoCount < FCNT_W'(FIFO_DEPTH));
    assign w_addrSum   = ADDR_W'(BASE_ADDR) + ADDR_W'(r_addrCnt);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= DONE;
        end else if (frame_start) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_frameDone) w_nextState = DONE;
                     else if (w_fifoRoom) w_nextState = WAIT;
            WAIT:    if (r_wcnt == '0) w_nextState = CAPTURE;
            CAPTURE: w_nextState = IDLE;
            DONE:    w_nextState = DONE;
            default: w_nextState = DONE;
        endcase
    end

    // A byte captured in the same cycle as frame_start belongs to the aborted frame and is dropped.
    always_comb begin
        w_issue   = 1'b0;
        w_push    = 1'b0;
        w_oeNNext = r_oeN;
        case (r_state)
            IDLE: begin
                if (w_frameDone) begin
                    w_oeNNext = 1'b1;
                end else if (w_fifoRoom) begin
                    w_issue   = 1'b1;
                    w_oeNNext = 1'b0;
                end
            end
            WAIT:    w_oeNNext = 1'b0;
            CAPTURE: begin
                w_push    = ~frame_start;
                w_oeNNext = 1'b1;
            end
            default: w_oeNNext = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_addrCnt   <= '0;
            r_wcnt      <= '0;
            r_flAddr    <= ADDR_W'(BASE_ADDR);
            r_oeN       <= 1'b1;
            r_underflow <= 1'b0;
        end else if (frame_start) begin
            r_addrCnt   <= '0;
            r_oeN       <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_oeN <= w_oeNNext;
            if (w_issue) begin
                r_flAddr <= w_addrSum;
                r_wcnt   <= WCNT_W'(ACC_CYCLES - 1);
            end else if (r_state == WAIT && r_wcnt != '0) begin
                r_wcnt <= r_wcnt - WCNT_W'(1);
            end
            if (w_push) begin
                r_addrCnt <= r_addrCnt + CNT_W'(1);
            end
            if (pix_rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    pix_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (CLOCK_50),
        .reset (reset),
        .flush (frame_start),
        .push  (w_push),
        .pop   (pix_rd),
        .din   (FL_DQ),
        .dout  (pix_data),
        .count (w_fifoCount),
        .empty (w_empty),
        .full  (w_full)
    );

    assign pix_valid = ~w_empty;
    assign underflow = r_underflow;
    assign busy      = (r_state != DONE);
    assign FL_ADDR   = r_flAddr;
    assign FL_OE_N   = r_oeN;
    assign FL_CE_N   = r_oeN;
    assign FL_WE_N   = 1'b1;
    assign FL_RST_N  = 1'b1;
endmodule

// File: tb/tb_flash_pixel_fetcher.sv
// Directed plus randomized-consumer bench for flash_pixel_fetcher, with a flash model returning FL_ADDR[7:0].
module tb_flash_pixel_fetcher;
    localparam int FRAME_BYTES = 20;
    localparam int ACC_CYCLES  = 5;
    localparam int FIFO_DEPTH  = 16;
    localparam int READ_CYCLES = ACC_CYCLES + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pix_rd;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        busy;
    logic [21:0] FL_ADDR;
    logic [7:0]  FL_DQ;
    logic        FL_OE_N;
    logic        FL_CE_N;
    logic        FL_WE_N;
    logic        FL_RST_N;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    bit expUnder;

    flash_pixel_fetcher #(
        .ADDR_W      (22),
        .BASE_ADDR   (0),
        .FRAME_BYTES (FRAME_BYTES),
        .ACC_CYCLES  (ACC_CYCLES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .busy        (busy),
        .FL_ADDR     (FL_ADDR),
        .FL_DQ       (FL_DQ),
        .FL_OE_N     (FL_OE_N),
        .FL_CE_N     (FL_CE_N),
        .FL_WE_N     (FL_WE_N),
        .FL_RST_N    (FL_RST_N)
    );

    always #5 clk = ~clk;

    // Flash returns the low address byte while enabled; 0xEE exposes a capture with the bus idle.
    assign FL_DQ = FL_OE_N ? 8'hEE : FL_ADDR[7:0];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fs, input logic rd);
        frame_start = fs;
        pix_rd      = rd;
    endtask

    task automatic pulseFrameStart();
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic countOeLows(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (!FL_OE_N) lows++;
            tick();
        end
    endtask

    task automatic waitReadAt(input logic [21:0] addr, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!FL_OE_N && FL_ADDR == addr) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Consumer model: bytes must arrive as BASE+0, +1, ... in order; underflow is the sticky OR of empty reads.
    task automatic consume(input string tag, input int startIdx, input int budget, output int endIdx, output bit finished);
        int idx;
        bit rd;
        idx      = startIdx;
        finished = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && !pix_valid) begin
                finished = 1'b1;
                break;
            end
            rd = ($urandom_range(0, 3) != 0);
            if (rd && pix_valid) begin
                checkOutput({tag, "_pix"}, 32'(pix_data), 32'(idx & 8'hFF));
                idx++;
            end else if (rd) begin
                expUnder = 1'b1;
            end
            applyStimulus(1'b0, rd);
            tick();
            applyStimulus(1'b0, 1'b0);
            checkOutput({tag, "_underflow"}, 32'(underflow), 32'(expUnder));
        end
        endIdx = idx;
    endtask

    initial begin
        int  lows;
        int  idx;
        bit  ok;

        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkOutput("rst_oe", 32'(FL_OE_N), 32'd1);
        checkOutput("rst_ce", 32'(FL_CE_N), 32'd1);
        checkOutput("rst_valid", 32'(pix_valid), 32'd0);
        checkOutput("rst_data", 32'(pix_data), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_addr", 32'(FL_ADDR), 32'd0);
        checkOutput("rst_we_rst", {30'd0, FL_WE_N, FL_RST_N}, 32'd3);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        countOeLows(10, lows);
        checkOutput("idle_before_start_oe", 32'(lows), 32'd0);
        checkOutput("idle_before_start_busy", 32'(busy), 32'd0);

        $display("[TB] frame 1: first read timing and FIFO fill");
        pulseFrameStart();
        checkOutput("f0_busy", 32'(busy), 32'd1);
        checkOutput("f0_oe", 32'(FL_OE_N), 32'd1);
        tick();
        checkOutput("f1_oe", 32'(FL_OE_N), 32'd0);
        checkOutput("f1_ce", 32'(FL_CE_N), 32'd0);
        checkOutput("f1_addr", 32'(FL_ADDR), 32'd0);
        repeat (ACC_CYCLES) tick();
        checkOutput("f6_valid", 32'(pix_valid), 32'd0);
        tick();
        checkOutput("f7_valid", 32'(pix_valid), 32'd1);
        checkOutput("f7_data", 32'(pix_data), 32'd0);
        checkOutput("f7_oe", 32'(FL_OE_N), 32'd1);
        tick();
        checkOutput("f8_oe", 32'(FL_OE_N), 32'd0);
        checkOutput("f8_addr", 32'(FL_ADDR), 32'd1);

        repeat (FIFO_DEPTH * READ_CYCLES + 20) tick();
        checkOutput("full_valid", 32'(pix_valid), 32'd1);
        checkOutput("full_head", 32'(pix_data), 32'd0);
        checkOutput("full_last_addr", 32'(FL_ADDR), 32'(FIFO_DEPTH - 1));
        countOeLows(20, lows);
        checkOutput("full_no_read", 32'(lows), 32'd0);

        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("pop1_head", 32'(pix_data), 32'd1);
        waitReadAt(22'(FIFO_DEPTH), 5, ok);
        checkOutput("pop1_refill_read", 32'(ok), 32'd1);
        repeat (READ_CYCLES + 3) tick();
        checkOutput("pop1_single_read", 32'(FL_OE_N), 32'd1);

        expUnder = 1'b0;
        consume("frame1", 1, 3000, idx, ok);
        checkOutput("frame1_finished", 32'(ok), 32'd1);
        checkOutput("frame1_count", 32'(idx), 32'(FRAME_BYTES));
        checkOutput("frame1_busy", 32'(busy), 32'd0);
        countOeLows(30, lows);
        checkOutput("frame1_quiet", 32'(lows), 32'd0);

        $display("[TB] frame 2: underflow, then abort during WAIT");
        pulseFrameStart();
        checkOutput("f2_underflow_clr", 32'(underflow), 32'd0);
        checkOutput("f2_flushed", 32'(pix_valid), 32'd0);
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("f2_underflow_set", 32'(underflow), 32'd1);
        repeat (30) tick();
        checkOutput("f2_underflow_sticky", 32'(underflow), 32'd1);
        checkOutput("f2_valid", 32'(pix_valid), 32'd1);
        waitReadAt(22'd5, 60, ok);
        checkOutput("f2_read5", 32'(ok), 32'd1);
        repeat (2) tick();
        pulseFrameStart();
        checkOutput("abort_oe", 32'(FL_OE_N), 32'd1);
        checkOutput("abort_valid", 32'(pix_valid), 32'd0);
        checkOutput("abort_underflow", 32'(underflow), 32'd0);
        tick();
        checkOutput("abort_restart_oe", 32'(FL_OE_N), 32'd0);
        checkOutput("abort_restart_addr", 32'(FL_ADDR), 32'd0);
        expUnder = 1'b0;
        consume("frame2", 0, 3000, idx, ok);
        checkOutput("frame2_finished", 32'(ok), 32'd1);
        checkOutput("frame2_count", 32'(idx), 32'(FRAME_BYTES));

        $display("[TB] frame 3: async reset during WAIT");
        pulseFrameStart();
        waitReadAt(22'd1, 30, ok);
        checkOutput("f3_read1", 32'(ok), 32'd1);
        checkOutput("f3_valid", 32'(pix_valid), 32'd1);
        repeat (2) tick();
        #3 reset = 1'b1;
        #1;
        checkOutput("arst_oe", 32'(FL_OE_N), 32'd1);
        checkOutput("arst_ce", 32'(FL_CE_N), 32'd1);
        checkOutput("arst_valid", 32'(pix_valid), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_addr", 32'(FL_ADDR), 32'd0);
        @(negedge clk) reset = 1'b0;
        countOeLows(10, lows);
        checkOutput("arst_stays_idle", 32'(lows), 32'd0);
        checkOutput("arst_busy_after", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
